// File: rtl/csa_accum_pkg.sv
// -----------------------------------------------------------------------------
// csa_accum_pkg
// Shared types and helpers for the sequential carry-save accumulator.
//   state_e       : controller states (ACCUM, RESOLVE, DONE)
//   csa_vec_t     : widest vector the helpers handle (results masked to width)
//   csa_pair_t    : {sum, weight-aligned carry} pair produced by csa3()
//   csa3()        : one 3:2 compression of three vectors, carry already shifted
//   csa_width_ok(): elaboration check that the result register cannot wrap
// -----------------------------------------------------------------------------
package csa_accum_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam int unsigned CSA_MAX_W = 64;

    typedef logic [CSA_MAX_W-1:0] csa_vec_t;

    typedef struct packed {
        csa_vec_t sum;
        csa_vec_t carry;
    } csa_pair_t;

    // 3:2 compression; the carry is returned shifted to its true weight and
    // truncated to 'width' bits, matching what the hardware row produces.
    function automatic csa_pair_t csa3(input csa_vec_t a, input csa_vec_t b,
                                       input csa_vec_t c, input int unsigned width);
        csa_pair_t r;
        csa_vec_t  mask;
        mask    = (width >= CSA_MAX_W) ? '1 : ((csa_vec_t'(1) << width) - csa_vec_t'(1));
        r.sum   = (a ^ b ^ c) & mask;
        r.carry = (((a & b) | (a & c) | (b & c)) << 1) & mask;
        return r;
    endfunction

    // True when n_ops worst-case operands of w bits fit in ow bits.
    function automatic bit csa_width_ok(input int unsigned w, input int unsigned n_ops,
                                        input int unsigned ow);
        longint unsigned max_op;
        longint unsigned max_sum;
        if (n_ops < 1 || w >= 63) return 1'b0;
        if (ow >= 63) return 1'b1;
        max_op  = (64'd1 << w) - 64'd1;
        max_sum = longint'(n_ops) * max_op;
        return max_sum < (64'd1 << ow);
    endfunction

endpackage

// File: rtl/csa_accum_seq_row.sv
// -----------------------------------------------------------------------------
// csa_row
// One row of W single-bit carry-save cells. Three W-bit vectors in, a W-bit
// sum and a W-bit carry out; the carry is already shifted one place left to
// its real weight and the bit shifted out of the top is dropped (modulo 2^W).
//   a_i, b_i, c_i : addends
//   sum_o         : bitwise sum
//   carry_o       : weight-aligned carry
// -----------------------------------------------------------------------------
module csa_row #(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    logic [W-1:0] maj;

    for (genvar i = 0; i < W; i++) begin : g_cell
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c_i[i];
        assign maj[i]   = (a_i[i] & b_i[i]) | (a_i[i] & c_i[i]) | (b_i[i] & c_i[i]);
    end

    assign carry_o = maj << 1;

endmodule

// File: rtl/csa_accum_seq.sv
// -----------------------------------------------------------------------------
// csa_accum_seq
// Time-multiplexed multi-operand adder. Each accepted operand is folded into a
// carry-save pair (S, C) with one 3:2 compression. After N_OPS operands the
// pair is resolved by repeated S^C / (S&C)<<1 passes until C is zero, and the
// binary total is offered on a valid/ready output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous abort, highest priority
//   in_valid/in_ready   : operand handshake, in_data is an unsigned operand
//   out_valid/out_ready : result handshake, out_sum is the frame total (S)
//   busy                : a frame is in progress
// -----------------------------------------------------------------------------
module csa_accum_seq
    import csa_accum_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned N_OPS     = 10,
    parameter int unsigned OUT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_sum,
    output logic                 busy
);

    localparam bit          WIDTH_OK = csa_width_ok(WIDTH, N_OPS, OUT_WIDTH);
    localparam int unsigned CNT_W    = $clog2(N_OPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS - 1);

    if (!WIDTH_OK) begin : g_width_check
        $error("csa_accum_seq: OUT_WIDTH too narrow for N_OPS*(2^WIDTH-1), or N_OPS < 1");
    end

    state_e               state_q, state_d;
    logic [OUT_WIDTH-1:0] s_q, s_d;
    logic [OUT_WIDTH-1:0] c_q, c_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [OUT_WIDTH-1:0] row_x;
    logic [OUT_WIDTH-1:0] row_sum;
    logic [OUT_WIDTH-1:0] row_carry;

    // The same row serves both phases: in RESOLVE the third input is zero,
    // which turns the 3:2 compression into the half-adder pass S^C, (S&C)<<1.
    assign row_x = (state_q == ACCUM) ? OUT_WIDTH'(in_data) : '0;

    csa_row #(
        .W(OUT_WIDTH)
    ) u_row (
        .a_i    (s_q),
        .b_i    (c_q),
        .c_i    (row_x),
        .sum_o  (row_sum),
        .carry_o(row_carry)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ACCUM;
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        s_d = row_sum;
                        c_d = row_carry;
                        if (cnt_q == LAST_CNT) begin
                            cnt_d   = '0;
                            state_d = RESOLVE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                RESOLVE: begin
                    if (c_q == '0) begin
                        state_d = DONE;
                    end else begin
                        s_d = row_sum;
                        c_d = row_carry;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        s_d     = '0;
                        c_d     = '0;
                        state_d = ACCUM;
                    end
                end
                default: begin
                    state_d = ACCUM;
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode registered state only.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_sum   = s_q;
    assign busy      = (state_q != ACCUM) || (cnt_q != '0);

endmodule

// File: tb/tb_csa_accum_seq.sv
module tb_csa_accum_seq;

    localparam int WIDTH     = 8;
    localparam int N_OPS     = 10;
    localparam int OUT_WIDTH = 12;
    localparam int RES_MAX   = OUT_WIDTH + 1;
    localparam int LAT_LIMIT = 40;

    logic                 clk;
    logic                 rst_n;
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_sum;
    logic                 busy;

    csa_accum_seq #(
        .WIDTH    (WIDTH),
        .N_OPS    (N_OPS),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0][7:0] ops;
        logic [7:0]      gap_max;
        logic [7:0]      stall;
        logic [15:0]     exp_sum;
        logic [7:0]      lat_min;
        logic [7:0]      lat_max;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q[$];
    int cov[RES_MAX+1];

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic drive_op(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run_frame(input logic [9:0][7:0] ops, input int gap_max, input int stall,
                             input int exp, input string tag, output int lat);
        bit                   ir_bad;
        bit                   stable_bad;
        logic [OUT_WIDTH-1:0] held;
        for (int i = 0; i < N_OPS; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            drive_op(ops[i]);
        end
        exp_q.push_back(exp);
        lat    = 1;
        ir_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready || !busy) ir_bad = 1'b1;
            if (lat >= LAT_LIMIT) break;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            n_chk++;
            $display("FAIL %s_timeout: out_valid=%0d after %0d cycles, expected 1", tag, out_valid, lat);
            void'(exp_q.pop_front());
            lat = 0;
            return;
        end
        check({tag, "_ready_low"}, ir_bad, 0);
        if (lat - 1 >= 1 && lat - 1 <= RES_MAX) cov[lat-1]++;
        held = out_sum;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL %s_sb: queue empty, got %0d", tag, out_sum);
        end else begin
            check({tag, "_sum"}, out_sum, exp_q.pop_front());
        end
        stable_bad = 1'b0;
        repeat (stall) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (!out_valid || out_sum != held || in_ready) stable_bad = 1'b1;
        end
        if (stall > 0) check({tag, "_stall_stable"}, stable_bad, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            tbl[5];
        logic [9:0][7:0] ops;
        int              lat;
        int              sum;
        int              hit;

        for (int i = 0; i <= RES_MAX; i++) cov[i] = 0;

        for (int i = 0; i < N_OPS; i++) begin
            tbl[0].ops[i] = 8'hFF;
            tbl[1].ops[i] = 8'h00;
            tbl[2].ops[i] = 8'(i + 1);
            tbl[3].ops[i] = 8'h80;
            tbl[4].ops[i] = (i % 2 == 0) ? 8'h55 : 8'hAA;
        end
        tbl[0].gap_max = 0; tbl[0].stall = 0; tbl[0].exp_sum = 2550; tbl[0].lat_min = 2; tbl[0].lat_max = 14;
        tbl[1].gap_max = 0; tbl[1].stall = 0; tbl[1].exp_sum = 0;    tbl[1].lat_min = 2; tbl[1].lat_max = 2;
        tbl[2].gap_max = 3; tbl[2].stall = 5; tbl[2].exp_sum = 55;   tbl[2].lat_min = 2; tbl[2].lat_max = 14;
        tbl[3].gap_max = 0; tbl[3].stall = 2; tbl[3].exp_sum = 1280; tbl[3].lat_min = 2; tbl[3].lat_max = 14;
        tbl[4].gap_max = 1; tbl[4].stall = 1; tbl[4].exp_sum = 1275; tbl[4].lat_min = 2; tbl[4].lat_max = 14;

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #23;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_sum", out_sum, 0);
        check("reset_busy", busy, 0);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            run_frame(tbl[v].ops, int'(tbl[v].gap_max), int'(tbl[v].stall),
                      int'(tbl[v].exp_sum), $sformatf("vec%0d", v), lat);
            check($sformatf("vec%0d_lat_in_range", v),
                  (lat >= int'(tbl[v].lat_min) && lat <= int'(tbl[v].lat_max)), 1);
        end

        // clear together with the 6th operand
        for (int i = 0; i < 5; i++) drive_op(8'h33);
        @(negedge clk);
        check("pre_clear_busy", busy, 1);
        in_valid = 1'b1;
        clear    = 1'b1;
        in_data  = 8'h44;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        @(negedge clk);
        check("clear_state", {in_ready, busy, out_valid}, 3'b100);
        check("clear_sum", out_sum, 0);
        for (int i = 0; i < N_OPS; i++) ops[i] = 8'h01;
        run_frame(ops, 0, 0, 10, "after_clear", lat);

        // asynchronous reset in the middle of RESOLVE
        for (int i = 0; i < N_OPS; i++) drive_op(8'hFF);
        #1;
        check("mid_resolve_state", {in_ready, busy}, 2'b01);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", {in_ready, out_valid, busy}, 3'b100);
        check("async_reset_sum", out_sum, 0);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N_OPS; i++) ops[i] = 8'h80;
        run_frame(ops, 0, 0, 1280, "after_reset", lat);

        // Random frames against a behavioural sum
        for (int f = 0; f < 1000; f++) begin
            int mode;
            mode = $urandom_range(0, 3);
            sum  = 0;
            for (int i = 0; i < N_OPS; i++) begin
                case (mode)
                    0:       ops[i] = 8'($urandom);
                    1:       ops[i] = 8'($urandom_range(200, 255));
                    2:       ops[i] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h01;
                    default: ops[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                endcase
                sum += int'(ops[i]);
            end
            run_frame(ops, $urandom_range(0, 1), $urandom_range(0, 2), sum,
                      $sformatf("rand%0d", f), lat);
        end

        check("scoreboard_drained", exp_q.size(), 0);

        hit = 0;
        for (int k = 1; k <= RES_MAX; k++) if (cov[k] > 0) hit++;
        $display("resolve-length bins hit: %0d of %0d", hit, RES_MAX);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
